// File: rtl/ebox_mbox_pkg.sv
// Shared types and helpers for the EBOX memory cycle sequencer.
//   cyc_state_t  : sequencer states
//   req_type_t   : memory cycle type decoded from the MCL qualifiers
//   decode_type  : MCL qualifiers -> req_type_t
//   is_wait      : states in which microcode is stalled and the timer runs
package ebox_mbox_pkg;

   localparam int unsigned DEFAULT_TIMEOUT = 255;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RDWAIT,
      RPWHOLD,
      WRWAIT
   } cyc_state_t;

   typedef enum logic [1:0] {
      RT_NONE,
      RT_READ,
      RT_WRITE,
      RT_RPW
   } req_type_t;

   // A read with pause+write is a read-pause-write; a write is only legal without a read.
   function automatic req_type_t decode_type(input logic ld_ar, input logic ld_arx,
                                             input logic pause, input logic wr);
      logic rd;
      rd = ld_ar | ld_arx;
      if (rd & pause & wr) return RT_RPW;
      else if (rd)         return RT_READ;
      else if (wr)         return RT_WRITE;
      else                 return RT_NONE;
   endfunction

   function automatic logic is_wait(input cyc_state_t s);
      return (s == REQ) || (s == RDWAIT) || (s == WRWAIT);
   endfunction

endpackage

// File: rtl/mbox_cyc_timer.sv
// Saturating wait-state counter with terminal-count detect.
//   clk, rst : clock, async active-high reset
//   clr      : restart count at 0 (wins over en)
//   en       : count this cycle
//   hit_c    : combinational; this enabled cycle is the MAX-th counted cycle
module mbox_cyc_timer #(
   parameter int unsigned MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit_c
);

   localparam int unsigned W = $clog2(MAX + 1);

   logic [W-1:0] cnt;

   // Count holds at MAX; the owner reacts to hit_c before that is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt <= '0;
      else if (clr)                     cnt <= '0;
      else if (en && (cnt != W'(MAX)))  cnt <= cnt + W'(1);
   end

   assign hit_c = en && (cnt == W'(MAX - 1));

endmodule

// File: rtl/ebox_mbox_cyc.sv
// EBOX-side memory cycle sequencer between MCL decode and the MBOX.
//   MCL side : cycReq + qualifiers (loadAR, loadARX, vmaPause, vmaWrite,
//              vmaFetch, vmaUser), vma
//   MBOX side: mboxReq, type bits, mboxAdr out; mboxAck, mboxRdValid, mboxWrDone in
//   Status   : memWait stall, arLoad/arxLoad strobes, rpwHold,
//              sticky nxm/protoErr cleared by errClr
module ebox_mbox_cyc
   import ebox_mbox_pkg::*;
#(
   parameter int unsigned ADDR_W  = 23,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              cycReq,
   input  logic              loadAR,
   input  logic              loadARX,
   input  logic              vmaPause,
   input  logic              vmaWrite,
   input  logic              vmaFetch,
   input  logic              vmaUser,
   input  logic [ADDR_W-1:0] vma,
   output logic              mboxReq,
   output logic              mboxRead,
   output logic              mboxWrite,
   output logic              mboxRPW,
   output logic              mboxFetch,
   output logic              mboxUser,
   output logic [ADDR_W-1:0] mboxAdr,
   input  logic              mboxAck,
   input  logic              mboxRdValid,
   input  logic              mboxWrDone,
   output logic              memWait,
   output logic              arLoad,
   output logic              arxLoad,
   output logic              rpwHold,
   output logic              nxm,
   output logic              protoErr,
   input  logic              errClr
);

   cyc_state_t state, state_nxt;
   req_type_t  lat_type, cap_type;
   logic       lat_ar, lat_arx;
   logic       capture, go_write, ar_nxt, arx_nxt, proto_set, nxm_set;
   logic       tmr_clr, tmr_en, tmo_c;

   assign cap_type = decode_type(loadAR, loadARX, vmaPause, vmaWrite);

   // Timer restarts on every entry into a waiting state, including REQ->RDWAIT.
   assign tmr_en  = is_wait(state);
   assign tmr_clr = is_wait(state_nxt) && (state_nxt != state);

   mbox_cyc_timer #(.MAX(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst   (RESET),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .hit_c (tmo_c)
   );

   // Next state and one-cycle events; a real completion beats a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      go_write  = 1'b0;
      ar_nxt    = 1'b0;
      arx_nxt   = 1'b0;
      proto_set = 1'b0;
      nxm_set   = 1'b0;
      case (state)
         IDLE: begin
            if (cycReq) begin
               if (cap_type == RT_NONE) begin
                  proto_set = 1'b1;
               end else begin
                  capture   = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            proto_set = cycReq;
            if (mboxAck) begin
               if (mboxRead) begin
                  if (mboxRdValid) begin
                     ar_nxt    = lat_ar;
                     arx_nxt   = lat_arx;
                     state_nxt = (lat_type == RT_RPW) ? RPWHOLD : IDLE;
                  end else begin
                     state_nxt = RDWAIT;
                  end
               end else begin
                  state_nxt = mboxWrDone ? IDLE : WRWAIT;
               end
            end else if (tmo_c) begin
               nxm_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         RDWAIT: begin
            proto_set = cycReq;
            if (mboxRdValid) begin
               ar_nxt    = lat_ar;
               arx_nxt   = lat_arx;
               state_nxt = (lat_type == RT_RPW) ? RPWHOLD : IDLE;
            end else if (tmo_c) begin
               nxm_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         RPWHOLD: begin
            if (cycReq) begin
               if (vmaWrite) begin
                  go_write  = 1'b1;
                  state_nxt = REQ;
               end else begin
                  proto_set = 1'b1;
               end
            end
         end
         WRWAIT: begin
            proto_set = cycReq;
            if (mboxWrDone) begin
               state_nxt = IDLE;
            end else if (tmo_c) begin
               nxm_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and all outputs registered together so they change on the same edge.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         lat_type  <= RT_NONE;
         lat_ar    <= 1'b0;
         lat_arx   <= 1'b0;
         mboxReq   <= 1'b0;
         mboxRead  <= 1'b0;
         mboxWrite <= 1'b0;
         mboxRPW   <= 1'b0;
         mboxFetch <= 1'b0;
         mboxUser  <= 1'b0;
         mboxAdr   <= '0;
         memWait   <= 1'b0;
         arLoad    <= 1'b0;
         arxLoad   <= 1'b0;
         rpwHold   <= 1'b0;
         nxm       <= 1'b0;
         protoErr  <= 1'b0;
      end else begin
         state    <= state_nxt;
         mboxReq  <= (state_nxt == REQ);
         memWait  <= is_wait(state_nxt);
         rpwHold  <= (state_nxt == RPWHOLD);
         arLoad   <= ar_nxt;
         arxLoad  <= arx_nxt;
         nxm      <= nxm_set   | (nxm & ~errClr);
         protoErr <= proto_set | (protoErr & ~errClr);
         if (capture) begin
            lat_type  <= cap_type;
            lat_ar    <= loadAR;
            lat_arx   <= loadARX;
            mboxRead  <= (cap_type != RT_WRITE);
            mboxWrite <= (cap_type == RT_WRITE);
            mboxRPW   <= (cap_type == RT_RPW);
            mboxFetch <= vmaFetch;
            mboxUser  <= vmaUser;
            mboxAdr   <= vma;
         end else if (go_write) begin
            // Write half of RPW reuses the latched address and RPW bit.
            mboxRead  <= 1'b0;
            mboxWrite <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ebox_mbox_cyc.md
Name: ebox_mbox_cyc

Overview:
- EBOX-side memory cycle sequencer, directly downstream of the MCL memory-control decode.
- Consumes MCL's cycle request (MBOX_CYC_REQ) with its qualifiers (LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE, VMA_FETCH, VMA_USER) and the VMA.
- Runs the request/acknowledge/data handshake with the MBOX.
- Produces the microcode memory-wait stall, AR/ARX load strobes, read-pause-write hold, and a non-existent-memory (NXM) timeout.

Parameters:
- ADDR_W, 23, VMA width (bits 13:35).
- TIMEOUT, 255, cycles in any waiting state before NXM is declared.

Ports:
- clk  in  1  EBOX clock.
- RESET  in  1  asynchronous, active-high master reset.
- cycReq  in  1  MCL.MBOX_CYC_REQ.
- loadAR, loadARX, vmaPause, vmaWrite, vmaFetch, vmaUser  in  1 each  MCL cycle qualifiers.
- vma  in  ADDR_W  virtual address.
- mboxReq  out  1  request to MBOX.
- mboxRead, mboxWrite, mboxRPW, mboxFetch, mboxUser  out  1 each  request type.
- mboxAdr  out  ADDR_W  latched address.
- mboxAck  in  1  MBOX accepted the request.
- mboxRdValid  in  1  read data on the bus.
- mboxWrDone  in  1  write complete.
- memWait  out  1  stall microcode.
- arLoad, arxLoad  out  1 each  one-cycle strobes.
- rpwHold  out  1  read half of a read-pause-write (RPW) is done; write half pending.
- nxm  out  1  sticky timeout flag.
- protoErr  out  1  sticky protocol-error flag.
- errClr  in  1  clears nxm and protoErr.

Behaviour:
- Reset: asynchronous. State IDLE; all outputs 0; timer 0; latched type and address 0. RESET asserted mid-cycle drops mboxReq immediately and abandons the cycle with no strobes.
- Type decode at capture:
  - rd = loadAR|loadARX.
  - RPW = rd & vmaPause & vmaWrite.
  - WRITE = vmaWrite & ~rd.
  - READ = rd & ~RPW.
  - cycReq with none of these: no state change, protoErr set.
- States: IDLE, REQ, RDWAIT, RPWHOLD, WRWAIT.
- IDLE & cycReq (legal type): latch type, vma, vmaFetch, vmaUser -> REQ. mboxReq rises the next cycle (latency 1).
- REQ: mboxReq=1; type outputs and mboxAdr stable. Stays in REQ until mboxAck.
  - On mboxAck, read/RPW -> RDWAIT; write -> WRWAIT.
  - mboxAck with mboxRdValid (or mboxWrDone) in the same cycle completes the cycle exactly as if RDWAIT/WRWAIT were entered.
- RDWAIT: on mboxRdValid:
  - arLoad = latched loadAR and arxLoad = latched loadARX, registered, one cycle wide.
  - Next state RPWHOLD if RPW, else IDLE.
- RPWHOLD: rpwHold=1, memWait=0; address retained.
  - cycReq & vmaWrite -> REQ with mboxWrite=1, mboxRPW=1, address not re-latched.
  - cycReq & ~vmaWrite -> protoErr set; state stays RPWHOLD.
- WRWAIT: on mboxWrDone -> IDLE.
- memWait = state in {REQ, RDWAIT, WRWAIT}, registered with the state.
- cycReq while in REQ, RDWAIT or WRWAIT: ignored and protoErr set.
- Timer:
  - Clears on entry to REQ, RDWAIT or WRWAIT; increments each cycle while in one of them.
  - Reaching TIMEOUT: nxm=1, state -> IDLE, mboxReq dropped, no AR/ARX strobe, RPW abandoned.
  - Width $clog2(TIMEOUT+1); no wrap, since the timeout fires first.
- Sticky flags: errClr clears nxm and protoErr. A set event in the same cycle as errClr wins.
- mboxAck, mboxRdValid or mboxWrDone in a state that does not expect it: ignored.

Decomposition:
- Package ebox_mbox_pkg:
  - cyc_state_t enum (IDLE, REQ, RDWAIT, RPWHOLD, WRWAIT).
  - req_type_t enum (RT_NONE, RT_READ, RT_WRITE, RT_RPW).
  - DEFAULT_TIMEOUT constant.
- Sub-module mbox_cyc_timer: parameterised saturating counter with clear/enable and a terminal-count output.

Test Plan:
- Read: cycReq with loadAR=1, vma=23'h012345; mboxAck at cycle 3, mboxRdValid at cycle 5 -> mboxReq cycles 1-3; mboxRead=1; mboxAdr=012345; memWait high cycles 1-5; arLoad pulse at cycle 6; arxLoad=0; IDLE.
- Write: vmaWrite=1; ack and wrDone in the same cycle -> single REQ cycle with mboxWrite=1; next state IDLE; no strobes.
- RPW: loadAR, vmaPause, vmaWrite; read completes -> rpwHold=1, memWait=0. A cycReq&vmaWrite 4 cycles later -> mboxReq with mboxWrite=1, mboxRPW=1, same address. wrDone -> IDLE.
- Timeout: TIMEOUT=8, read, no mboxAck -> nxm=1 after 8 REQ cycles, mboxReq=0, arLoad never pulses. errClr -> nxm=0.
- Protocol: cycReq during RDWAIT -> protoErr=1, cycle completes normally. cycReq with no qualifiers in IDLE -> protoErr=1, stays IDLE.
- Reset: assert RESET during RDWAIT -> mboxReq and memWait drop asynchronously; after release, IDLE with all outputs 0.
